// File: rtl/color_classify_nch_pkg.sv
// Shared types and helpers for the N-channel colour classifier:
// class codes, the per-channel config record and RGB565 unpack/repack.
package color_classify_nch_pkg;

   localparam int C_W  = 6;
   localparam int N_CH = 4;
   localparam int V_W  = C_W + 2;

   localparam logic [3:0] CLS_BLACK = 4'(N_CH);
   localparam logic [3:0] CLS_WHITE = 4'(N_CH + 1);

   typedef struct packed {
      logic [C_W-1:0] r;
      logic [C_W-1:0] g;
      logic [C_W-1:0] b;
   } rgb_t;

   typedef struct packed {
      logic             en;
      logic [3*C_W-1:0] ref_rgb;
      logic [V_W-1:0]   err;
      logic [V_W-1:0]   vmin;
      logic [V_W-1:0]   vmax;
      logic [15:0]      color;
   } ch_cfg_t;

   // Components are left-aligned in C_W bits so wider builds keep the same scale.
   function automatic rgb_t unpack565(input logic [15:0] px);
      rgb_t c;
      c.r = C_W'(px[15:11]) << (C_W - 5);
      c.g = C_W'(px[10:5])  << (C_W - 6);
      c.b = C_W'(px[4:0])   << (C_W - 5);
      return c;
   endfunction

   function automatic logic [15:0] repack565(input rgb_t c);
      return {c.r[C_W-1 -: 5], c.g[C_W-1 -: 6], c.b[C_W-1 -: 5]};
   endfunction

endpackage

// File: rtl/color_classify_nch_if.sv
// Pixel, configuration and statistics bus of the colour classifier.
interface color_classify_nch_if #(
   parameter int P_W   = 12,
   parameter int CNT_W = 20
) ();
   import color_classify_nch_pkg::*;

   logic             cfg_we;
   logic [2:0]       cfg_addr;
   logic             cfg_en;
   logic [3*C_W-1:0] cfg_ref;
   logic [V_W-1:0]   cfg_err;
   logic [V_W-1:0]   cfg_vmin;
   logic [V_W-1:0]   cfg_vmax;
   logic [15:0]      cfg_color;
   logic [V_W-1:0]   i_wb_threshold;
   logic             i_vs;
   logic             i_valid;
   logic [15:0]      i_data;

   logic             o_valid;
   logic [15:0]      o_data;
   logic [15:0]      o_data_raw;
   logic [3:0]       o_class;
   logic [P_W-1:0]   o_x;
   logic [P_W-1:0]   o_y;
   logic             o_stat_valid;
   logic [2:0]       o_stat_idx;
   logic [CNT_W-1:0] o_stat_cnt;
   logic             o_stat_last;

   modport master (
      output cfg_we, cfg_addr, cfg_en, cfg_ref, cfg_err, cfg_vmin, cfg_vmax, cfg_color,
      output i_wb_threshold, i_vs, i_valid, i_data,
      input  o_valid, o_data, o_data_raw, o_class, o_x, o_y,
      input  o_stat_valid, o_stat_idx, o_stat_cnt, o_stat_last
   );

   modport slave (
      input  cfg_we, cfg_addr, cfg_en, cfg_ref, cfg_err, cfg_vmin, cfg_vmax, cfg_color,
      input  i_wb_threshold, i_vs, i_valid, i_data,
      output o_valid, o_data, o_data_raw, o_class, o_x, o_y,
      output o_stat_valid, o_stat_idx, o_stat_cnt, o_stat_last
   );

endinterface

// File: rtl/color_classify_nch_match_ch.sv
// One channel's match path: S1 captures abs differences and the channel config,
// S2 registers the match decision together with the channel's display colour.
module color_match_ch
   import color_classify_nch_pkg::*;
(
   input  logic           sys_clk,
   input  logic           sys_rst,
   input  rgb_t           px,
   input  logic [V_W-1:0] v_s1,
   input  ch_cfg_t        cfg,
   output logic           match,
   output logic [15:0]    color
);

   function automatic logic [V_W-1:0] absdiff(input logic [C_W-1:0] a, input logic [C_W-1:0] b);
      return (a >= b) ? V_W'(a - b) : V_W'(b - a);
   endfunction

   rgb_t           ref_px;
   logic [V_W-1:0] d_r, d_g, d_b, err_q, vmin_q, vmax_q;
   logic           en_q;
   logic [15:0]    color_q;

   assign ref_px = rgb_t'(cfg.ref_rgb);

   // NOTE: registers use <= so each stage samples the previous stage's pre-edge value.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         d_r     <= '0;
         d_g     <= '0;
         d_b     <= '0;
         en_q    <= 1'b0;
         err_q   <= '0;
         vmin_q  <= '0;
         vmax_q  <= '0;
         color_q <= '0;
         match   <= 1'b0;
         color   <= '0;
      end else begin
         d_r     <= absdiff(px.r, ref_px.r);
         d_g     <= absdiff(px.g, ref_px.g);
         d_b     <= absdiff(px.b, ref_px.b);
         en_q    <= cfg.en;
         err_q   <= cfg.err;
         vmin_q  <= cfg.vmin;
         vmax_q  <= cfg.vmax;
         color_q <= cfg.color;
         match   <= en_q && ((d_r + d_g + d_b) <= err_q) && (v_s1 >= vmin_q) && (v_s1 <= vmax_q);
         color   <= color_q;
      end
   end

endmodule

// File: rtl/color_classify_nch.sv
// N-channel RGB565 colour classifier: config regfile, 3-stage classify pipeline,
// pixel position tracking and per-frame channel statistics with serial dump.
module color_classify_nch
   import color_classify_nch_pkg::*;
#(
   parameter int P_W   = 12,
   parameter int IMG_X = 640,
   parameter int IMG_Y = 480,
   parameter int CNT_W = 20
) (
   input logic                 sys_clk,
   input logic                 sys_rst,
   color_classify_nch_if.slave bus
);

   typedef enum logic {ST_RUN, ST_DUMP} st_t;

   ch_cfg_t          cfg_q [N_CH];
   rgb_t             in_px, s1_px;
   logic             s1_valid, s2_valid, s2_above;
   logic [V_W-1:0]   s1_v, s1_thr;
   logic [P_W-1:0]   cnt_x, cnt_y, cur_x, cur_y, s1_x, s1_y, s2_x, s2_y;
   logic [15:0]      s2_raw, sel_data;
   logic [3:0]       sel_class;
   logic [N_CH-1:0]  s2_match, hit;
   logic [15:0]      s2_color [N_CH];
   logic [CNT_W-1:0] live_cnt [N_CH];
   logic [CNT_W-1:0] shadow_cnt [N_CH];
   st_t              state, state_nx;
   logic [2:0]       idx, idx_nx;

   assign in_px = unpack565(bus.i_data);
   assign s1_v  = V_W'(s1_px.r) + V_W'(s1_px.g) + V_W'(s1_px.b);
   assign cur_x = bus.i_vs ? '0 : cnt_x;
   assign cur_y = bus.i_vs ? '0 : cnt_y;

   // NOTE: the config array is reset explicitly so every channel comes up disabled.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         for (int k = 0; k < N_CH; k++) cfg_q[k] <= '0;
      end else if (bus.cfg_we) begin
         for (int k = 0; k < N_CH; k++)
            if (bus.cfg_addr == 3'(k))
               cfg_q[k] <= '{en: bus.cfg_en, ref_rgb: bus.cfg_ref, err: bus.cfg_err,
                             vmin: bus.cfg_vmin, vmax: bus.cfg_vmax, color: bus.cfg_color};
      end
   end

   // The pixel that arrives with i_vs is (0,0); the counters hold the next pixel's position.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         cnt_x <= '0;
         cnt_y <= '0;
      end else if (bus.i_valid) begin
         if (cur_x == P_W'(IMG_X - 1)) begin
            cnt_x <= '0;
            cnt_y <= (cur_y == P_W'(IMG_Y - 1)) ? '0 : cur_y + 1'b1;
         end else begin
            cnt_x <= cur_x + 1'b1;
            cnt_y <= cur_y;
         end
      end else if (bus.i_vs) begin
         cnt_x <= '0;
         cnt_y <= '0;
      end
   end

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      color_match_ch u_match (
         .sys_clk (sys_clk),
         .sys_rst (sys_rst),
         .px      (in_px),
         .v_s1    (s1_v),
         .cfg     (cfg_q[k]),
         .match   (s2_match[k]),
         .color   (s2_color[k])
      );
   end

   // NOTE: defaults come first so no path through a combinational block infers a latch.
   always_comb begin
      sel_data  = s2_above ? 16'h0000 : 16'hFFFF;
      sel_class = s2_above ? CLS_BLACK : CLS_WHITE;
      for (int k = N_CH - 1; k >= 0; k--) begin
         if (s2_match[k]) begin
            sel_data  = s2_color[k];
            sel_class = 4'(k);
         end
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         s1_valid       <= 1'b0;
         s1_px          <= '0;
         s1_x           <= '0;
         s1_y           <= '0;
         s1_thr         <= '0;
         s2_valid       <= 1'b0;
         s2_above       <= 1'b0;
         s2_raw         <= '0;
         s2_x           <= '0;
         s2_y           <= '0;
         bus.o_valid    <= 1'b0;
         bus.o_data     <= '0;
         bus.o_data_raw <= '0;
         bus.o_class    <= '0;
         bus.o_x        <= '0;
         bus.o_y        <= '0;
      end else begin
         s1_valid       <= bus.i_valid;
         s1_px          <= in_px;
         s1_x           <= cur_x;
         s1_y           <= cur_y;
         s1_thr         <= bus.i_wb_threshold;
         s2_valid       <= s1_valid;
         s2_above       <= s1_v > s1_thr;
         s2_raw         <= repack565(s1_px);
         s2_x           <= s1_x;
         s2_y           <= s1_y;
         bus.o_valid    <= s2_valid;
         bus.o_data     <= sel_data;
         bus.o_data_raw <= s2_raw;
         bus.o_class    <= sel_class;
         bus.o_x        <= s2_x;
         bus.o_y        <= s2_y;
      end
   end

   always_comb begin
      hit = '0;
      for (int k = 0; k < N_CH; k++) hit[k] = bus.o_valid && (bus.o_class == 4'(k));
   end

   // A pixel leaving the pipeline in the snapshot cycle belongs to the new frame.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         for (int k = 0; k < N_CH; k++) begin
            live_cnt[k]   <= '0;
            shadow_cnt[k] <= '0;
         end
      end else begin
         for (int k = 0; k < N_CH; k++) begin
            if (bus.i_vs) begin
               shadow_cnt[k] <= live_cnt[k];
               live_cnt[k]   <= CNT_W'(hit[k]);
            end else if (hit[k] && (live_cnt[k] != '1)) begin
               live_cnt[k] <= live_cnt[k] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state <= ST_RUN;
         idx   <= '0;
      end else begin
         state <= state_nx;
         idx   <= idx_nx;
      end
   end

   always_comb begin
      state_nx         = state;
      idx_nx           = idx;
      bus.o_stat_valid = 1'b0;
      bus.o_stat_idx   = '0;
      bus.o_stat_cnt   = '0;
      bus.o_stat_last  = 1'b0;
      if (bus.i_vs) begin
         state_nx = ST_DUMP;
         idx_nx   = '0;
      end else if (state == ST_DUMP) begin
         if (idx == 3'(N_CH - 1)) state_nx = ST_RUN;
         else                     idx_nx   = idx + 1'b1;
      end
      if (state == ST_DUMP) begin
         bus.o_stat_valid = 1'b1;
         bus.o_stat_idx   = idx;
         bus.o_stat_last  = (idx == 3'(N_CH - 1));
         for (int k = 0; k < N_CH; k++)
            if (idx == 3'(k)) bus.o_stat_cnt = shadow_cnt[k];
      end
   end

endmodule

// File: tb/tb_color_classify_nch.sv
// Bench for color_classify_nch: two instances (20-bit and 4-bit statistics counters)
// share one stimulus stream and are compared against a queue-based reference model.
module tb_color_classify_nch;
   import color_classify_nch_pkg::*;

   localparam int P_W   = 12;
   localparam int IMG_X = 8;
   localparam int IMG_Y = 4;
   localparam int SAT_A = (1 << 20) - 1;
   localparam int SAT_B = 15;

   logic sys_clk = 1'b0;
   logic sys_rst;
   always #5 sys_clk = ~sys_clk;

   color_classify_nch_if #(.P_W(P_W), .CNT_W(20)) bus_a ();
   color_classify_nch_if #(.P_W(P_W), .CNT_W(4))  bus_b ();

   color_classify_nch #(.P_W(P_W), .IMG_X(IMG_X), .IMG_Y(IMG_Y), .CNT_W(20)) u_dut_a (
      .sys_clk (sys_clk), .sys_rst (sys_rst), .bus (bus_a));
   color_classify_nch #(.P_W(P_W), .IMG_X(IMG_X), .IMG_Y(IMG_Y), .CNT_W(4)) u_dut_b (
      .sys_clk (sys_clk), .sys_rst (sys_rst), .bus (bus_b));

   // stimulus for the next clock edge
   logic             s_rst = 1'b0, s_we = 1'b0, s_en = 1'b0, s_vs = 1'b0, s_valid = 1'b0;
   logic [2:0]       s_addr = '0;
   logic [3*C_W-1:0] s_ref = '0;
   logic [V_W-1:0]   s_err = '0, s_vmin = '0, s_vmax = '0, s_thr = '0;
   logic [15:0]      s_color = '0, s_data = '0;

   typedef struct {int tag; logic [15:0] data; logic [15:0] raw; int cls; int x; int y;} pix_exp_t;
   typedef struct {int tag; int idx; int cnt_a; int cnt_b; bit last;} stat_exp_t;

   int          m_en [N_CH], m_r0 [N_CH], m_g0 [N_CH], m_b0 [N_CH];
   int          m_err [N_CH], m_vmin [N_CH], m_vmax [N_CH];
   logic [15:0] m_color [N_CH];
   int          live_a [N_CH], live_b [N_CH];
   pix_exp_t    pq [$];
   stat_exp_t   sq [$];
   int          npix = 0, cyc = 0, cur_cls = 0;
   bit          cur_valid = 1'b0;
   int          n_vec = 0, n_err = 0;
   logic [15:0] base [N_CH];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %0h, expected %0h", tag, cyc, got, exp);
      end
   endtask

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic logic [3*C_W-1:0] ref_of(input logic [15:0] p);
      return {p[15:11], 1'b0, p[10:5], p[4:0], 1'b0};
   endfunction

   // Classification straight from the rules: lowest enabled channel in range wins.
   task automatic model_pixel(input logic [15:0] p, output logic [15:0] d, output int cls);
      int r, g, b, v, sad;
      r = int'(p[15:11]) * 2;
      g = int'(p[10:5]);
      b = int'(p[4:0]) * 2;
      v = r + g + b;
      cls = -1;
      for (int k = 0; k < N_CH; k++) begin
         sad = iabs(r - m_r0[k]) + iabs(g - m_g0[k]) + iabs(b - m_b0[k]);
         if (cls < 0 && m_en[k] != 0 && sad <= m_err[k] && v >= m_vmin[k] && v <= m_vmax[k])
            cls = k;
      end
      if (cls >= 0)          d = m_color[cls];
      else if (v > int'(s_thr)) begin d = 16'h0000; cls = N_CH;     end
      else                       begin d = 16'hFFFF; cls = N_CH + 1; end
   endtask

   // Advance the model across the coming clock edge.
   task automatic model_step();
      logic [15:0] d;
      int cls, n;
      if (s_rst) begin
         pq.delete();
         sq.delete();
         for (int k = 0; k < N_CH; k++) begin
            m_en[k] = 0; m_r0[k] = 0; m_g0[k] = 0; m_b0[k] = 0;
            m_err[k] = 0; m_vmin[k] = 0; m_vmax[k] = 0; m_color[k] = '0;
            live_a[k] = 0; live_b[k] = 0;
         end
         npix = 0;
         return;
      end
      if (s_vs) begin
         sq.delete();
         for (int k = 0; k < N_CH; k++) begin
            sq.push_back('{cyc + 1 + k, k, live_a[k], live_b[k], (k == N_CH - 1)});
            live_a[k] = 0;
            live_b[k] = 0;
         end
      end
      if (cur_valid && cur_cls < N_CH) begin
         if (live_a[cur_cls] < SAT_A) live_a[cur_cls]++;
         if (live_b[cur_cls] < SAT_B) live_b[cur_cls]++;
      end
      if (s_valid) begin
         n = s_vs ? 0 : npix;
         model_pixel(s_data, d, cls);
         pq.push_back('{cyc + 3, d, s_data, cls, n % IMG_X, n / IMG_X});
         npix = (n + 1) % (IMG_X * IMG_Y);
      end else if (s_vs) begin
         npix = 0;
      end
      if (s_we && int'(s_addr) < N_CH) begin
         m_en[s_addr]    = int'(s_en);
         m_r0[s_addr]    = int'(s_ref[3*C_W-1 -: C_W]);
         m_g0[s_addr]    = int'(s_ref[2*C_W-1 -: C_W]);
         m_b0[s_addr]    = int'(s_ref[C_W-1:0]);
         m_err[s_addr]   = int'(s_err);
         m_vmin[s_addr]  = int'(s_vmin);
         m_vmax[s_addr]  = int'(s_vmax);
         m_color[s_addr] = s_color;
      end
   endtask

   task automatic check_cycle();
      pix_exp_t  e;
      stat_exp_t s;
      cur_valid = 1'b0;
      if (pq.size() > 0 && pq[0].tag == cyc) begin
         e = pq.pop_front();
         cur_valid = 1'b1;
         cur_cls   = e.cls;
         check("o_valid",    32'(bus_a.o_valid), 1);
         check("o_valid_b",  32'(bus_b.o_valid), 1);
         check("o_data",     32'(bus_a.o_data), 32'(e.data));
         check("o_class",    32'(bus_a.o_class), 32'(e.cls));
         check("o_class_b",  32'(bus_b.o_class), 32'(e.cls));
         check("o_data_raw", 32'(bus_a.o_data_raw), 32'(e.raw));
         check("o_x",        32'(bus_a.o_x), 32'(e.x));
         check("o_y",        32'(bus_a.o_y), 32'(e.y));
      end else begin
         check("o_valid_idle",   32'(bus_a.o_valid), 0);
         check("o_valid_idle_b", 32'(bus_b.o_valid), 0);
      end
      if (sq.size() > 0 && sq[0].tag == cyc) begin
         s = sq.pop_front();
         check("stat_valid",   32'(bus_a.o_stat_valid), 1);
         check("stat_valid_b", 32'(bus_b.o_stat_valid), 1);
         check("stat_idx",     32'(bus_a.o_stat_idx), 32'(s.idx));
         check("stat_cnt",     32'(bus_a.o_stat_cnt), 32'(s.cnt_a));
         check("stat_cnt_b",   32'(bus_b.o_stat_cnt), 32'(s.cnt_b));
         check("stat_last",    32'(bus_a.o_stat_last), 32'(s.last));
         check("stat_last_b",  32'(bus_b.o_stat_last), 32'(s.last));
      end else begin
         check("stat_idle",   32'(bus_a.o_stat_valid), 0);
         check("stat_idle_b", 32'(bus_b.o_stat_valid), 0);
      end
   endtask

   task automatic drive_bus();
      sys_rst              = s_rst;
      bus_a.cfg_we         = s_we;    bus_b.cfg_we         = s_we;
      bus_a.cfg_addr       = s_addr;  bus_b.cfg_addr       = s_addr;
      bus_a.cfg_en         = s_en;    bus_b.cfg_en         = s_en;
      bus_a.cfg_ref        = s_ref;   bus_b.cfg_ref        = s_ref;
      bus_a.cfg_err        = s_err;   bus_b.cfg_err        = s_err;
      bus_a.cfg_vmin       = s_vmin;  bus_b.cfg_vmin       = s_vmin;
      bus_a.cfg_vmax       = s_vmax;  bus_b.cfg_vmax       = s_vmax;
      bus_a.cfg_color      = s_color; bus_b.cfg_color      = s_color;
      bus_a.i_wb_threshold = s_thr;   bus_b.i_wb_threshold = s_thr;
      bus_a.i_vs           = s_vs;    bus_b.i_vs           = s_vs;
      bus_a.i_valid        = s_valid; bus_b.i_valid        = s_valid;
      bus_a.i_data         = s_data;  bus_b.i_data         = s_data;
   endtask

   task automatic tick();
      drive_bus();
      model_step();
      @(posedge sys_clk);
      cyc++;
      @(negedge sys_clk);
      check_cycle();
      s_rst = 1'b0; s_we = 1'b0; s_vs = 1'b0; s_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic px(input logic [15:0] d);
      s_valid = 1'b1;
      s_data  = d;
      tick();
   endtask

   task automatic cfg(input int a, input bit en, input int r0, input int g0, input int b0,
                      input int err, input int vmin, input int vmax, input logic [15:0] color);
      s_we = 1'b1; s_addr = 3'(a); s_en = en;
      s_ref = {C_W'(r0), C_W'(g0), C_W'(b0)};
      s_err = V_W'(err); s_vmin = V_W'(vmin); s_vmax = V_W'(vmax); s_color = color;
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      s_thr = 8'd100;
      repeat (3) begin s_rst = 1'b1; tick(); end
      check("rst_o_data",     32'(bus_a.o_data), 0);
      check("rst_o_class",    32'(bus_a.o_class), 0);
      check("rst_o_data_raw", 32'(bus_a.o_data_raw), 0);
      check("rst_o_xy",       32'({bus_a.o_x, bus_a.o_y}), 0);
      check("rst_stat_cnt",   32'(bus_a.o_stat_cnt), 0);

      // single channel hit, then priority between two overlapping channels
      cfg(0, 1'b1, 63, 0, 0, 20, 10, 200, 16'h07E0);
      px(16'hF800);
      idle(4);
      cfg(1, 1'b1, 62, 0, 0, 63, 0, 255, 16'h001F);
      px(16'hF800);
      cfg(0, 1'b0, 63, 0, 0, 20, 10, 200, 16'h07E0);
      px(16'hF800);
      idle(4);

      // black/white fallback
      cfg(1, 1'b0, 62, 0, 0, 63, 0, 255, 16'h001F);
      px(16'hFFFF);
      px(16'h0000);
      idle(4);

      // statistics: 10 ch0 + 5 ch1 pixels, then an empty frame
      cfg(0, 1'b1, 63, 0, 0, 20, 10, 200, 16'h07E0);
      cfg(1, 1'b1, 62, 0, 0, 63, 0, 255, 16'h001F);
      s_vs = 1'b1; tick();
      idle(6);
      repeat (10) px(16'hF800);
      repeat (5)  px(16'h7800);
      idle(4);
      s_vs = 1'b1; tick();
      idle(6);
      s_vs = 1'b1; tick();
      idle(6);

      // saturation on the narrow counter, then a dump aborted on its second word
      repeat (20) px(16'hF800);
      idle(4);
      s_vs = 1'b1; tick();
      tick();
      s_vs = 1'b1; tick();
      idle(6);

      // reset with pixels in flight
      px(16'hF800);
      px(16'hF800);
      s_rst = 1'b1; px(16'hF800);
      idle(4);
      px(16'hF800);
      s_thr = 8'd40; px(16'hF800);
      s_thr = 8'd100;
      idle(4);

      // randomized traffic around per-channel reference colours
      for (int k = 0; k < N_CH; k++) begin
         base[k] = 16'($urandom);
         s_we = 1'b1; s_addr = 3'(k); s_en = 1'b1; s_ref = ref_of(base[k]);
         s_err = V_W'($urandom_range(0, 40)); s_vmin = V_W'($urandom_range(0, 60));
         s_vmax = V_W'($urandom_range(120, 255)); s_color = 16'($urandom);
         tick();
      end
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 99) < 4) begin
            s_we = 1'b1; s_addr = 3'($urandom_range(0, 7)); s_en = ($urandom_range(0, 4) != 0);
            if (int'(s_addr) < N_CH) begin
               base[s_addr] = 16'($urandom);
               s_ref = ref_of(base[s_addr]);
            end else begin
               s_ref = 18'($urandom);
            end
            s_err = V_W'($urandom_range(0, 40)); s_vmin = V_W'($urandom_range(0, 60));
            s_vmax = V_W'($urandom_range(120, 255)); s_color = 16'($urandom);
         end
         if ($urandom_range(0, 99) < 2) s_thr = V_W'($urandom_range(20, 200));
         if ($urandom_range(0, 99) < 2) s_vs = 1'b1;
         if (i == 300) s_rst = 1'b1;
         if ($urandom_range(0, 99) < 75) begin
            s_valid = 1'b1;
            if ($urandom_range(0, 2) == 0) s_data = 16'($urandom);
            else s_data = base[$urandom_range(0, N_CH - 1)] ^ (16'($urandom) & 16'h0821);
         end
         tick();
      end
      s_vs = 1'b1; tick();
      idle(8);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/color_classify_nch.md
Name: color_classify_nch

Overview:
- N-channel successor to the fixed four-colour classifier in the post-processing chain, sitting between camera RGB565 capture and display/rect logic.
- Each channel has runtime-programmable reference colour, tolerance, brightness window, enable and display colour.
- Classifies each pixel by lowest-index match, or falls back to black/white by brightness.
- Also accumulates per-channel pixel counts per frame and dumps them serially at frame end.

Parameters:
C_W, 6, colour component width after unpack
P_W, 12, pixel position counter width
N_CH, 4, number of colour channels (1..8)
IMG_X, 640, pixels per line
IMG_Y, 480, lines per frame
CNT_W, 20, per-channel statistics counter width

Ports:
sys_clk  in  1  clock
sys_rst  in  1  synchronous reset, active-high
cfg_we  in  1  config write strobe
cfg_addr  in  3  channel index; values >= N_CH ignored
cfg_en  in  1  channel enable
cfg_ref  in  3*C_W  {R0,G0,B0}
cfg_err  in  C_W+2  max sum of absolute differences
cfg_vmin  in  C_W+2  min brightness
cfg_vmax  in  C_W+2  max brightness
cfg_color  in  16  RGB565 display colour for the channel
i_wb_threshold  in  C_W+2  black/white split
i_vs  in  1  one-cycle frame-start pulse
i_valid  in  1  pixel strobe
i_data  in  16  RGB565 pixel
o_valid  out  1  classified pixel strobe
o_data  out  16  recoloured pixel
o_data_raw  out  16  delayed input pixel
o_class  out  4  0..N_CH-1 = channel; N_CH = black; N_CH+1 = white
o_x  out  P_W  column of o_data
o_y  out  P_W  row of o_data
o_stat_valid  out  1  statistics word strobe
o_stat_idx  out  3  channel of o_stat_cnt
o_stat_cnt  out  CNT_W  pixel count of last frame
o_stat_last  out  1  marks final statistics word

Behaviour:
- Reset: all outputs 0. All channel registers 0, so channels are disabled. Counters 0. FSM in RUN.
- Unpack:
  - R = {i_data[15:11],1'b0}
  - G = i_data[10:5]
  - B = {i_data[4:0],1'b0}
  - For C_W > 6, left-align and zero-fill.
- Per-channel match, all arithmetic in C_W+2 bits:
  - sad = |R-R0|+|G-G0|+|B-B0|
  - V = R+G+B
  - match = en && sad <= err && vmin <= V <= vmax
- Pipeline: fixed 3-cycle latency, i_valid at cycle t gives o_valid at t+3. Stages:
  - S1: register unpacked pixel and abs differences.
  - S2: sums and compares.
  - S3: priority select and output registers.
- Bubbles propagate; no backpressure.
- Select:
  - Lowest matching index wins: o_data = cfg_color of that channel, o_class = index.
  - No match and V > i_wb_threshold: o_data = 16'h0000, o_class = N_CH.
  - Otherwise: o_data = 16'hFFFF, o_class = N_CH+1.
- o_data_raw: input pixel re-packed from R/G/B, aligned with o_data.
- Position:
  - cnt_x/cnt_y advance on i_valid. x wraps at IMG_X-1, then y increments; y wraps at IMG_Y-1.
  - i_vs forces both to 0. The pixel accompanying i_vs is position (0,0).
  - Position is pipelined so o_x/o_y align with o_valid.
- Config:
  - Write on cfg_we with cfg_addr < N_CH. Applies to pixels entering S1 on the next cycle.
  - Pixels already in flight use the values they captured.
- Statistics:
  - Each live counter increments when o_valid and o_class equal its index, saturating at 2^CNT_W-1.
- Statistics FSM:
  - RUN: on i_vs, copy all live counters to shadow registers and clear live counters. An o_valid in the same cycle counts into the new frame. Go to DUMP with idx = 0.
  - DUMP: each cycle, o_stat_valid = 1, o_stat_idx = idx, o_stat_cnt = shadow[idx]. o_stat_last = 1 on idx N_CH-1, then return to RUN.
  - i_vs during DUMP: take a new snapshot and restart at idx 0. No o_stat_last is issued for the aborted dump.
  - Pixels still in the pipeline at i_vs count into the new frame (accepted up to 3-pixel skew).
- Reset mid-operation:
  - Synchronous. In-flight pixels are dropped.
  - o_valid/o_stat_valid are 0 the cycle after sys_rst is sampled.
  - Configuration returns to disabled.

Decomposition:
- Shared package holds:
  - class code constants CLS_BLACK = N_CH, CLS_WHITE = N_CH+1
  - a packed channel-config record {en, ref, err, vmin, vmax, color}
  - unpack/repack functions
- One sub-module, color_match_ch: S1/S2 for a single channel; inputs R, G, B and its config, output a registered match. It is instantiated N_CH times via generate.
- The top module holds the config regfile, priority select, position counters, statistics counters and FSM.

Test Plan:
1. ch0 ref (63,0,0), err 20, vmin 10, vmax 200, color 16'h07E0, en. Input 16'hF800 (R62 G0 B0; sad 1, V 62) -> three cycles later o_valid = 1, o_data = 16'h07E0, o_class = 0, o_data_raw = 16'hF800.
2. ch1 ref (62,0,0), err 63, color 16'h001F, both ch0 and ch1 enabled. Input 16'hF800 -> o_data = 16'h07E0 (ch0 priority). Disable ch0 via cfg write -> next pixel gives o_data = 16'h001F, o_class = 1.
3. All channels disabled, threshold 100. Input 16'hFFFF (V = 187) -> o_data 16'h0000, class 4. Input 16'h0000 -> o_data 16'hFFFF, class 5.
4. Stats with N_CH = 4. Feed 10 ch0 pixels and 5 ch1 pixels, then pulse i_vs -> four consecutive o_stat_valid cycles with (idx, cnt) = (0,10), (1,5), (2,0), (3,0); o_stat_last on idx 3. A following empty frame dumps all zeros.
5. CNT_W = 4 with 20 ch0 pixels -> o_stat_cnt = 15 for idx 0. Pulse i_vs again on the second dump cycle -> dump restarts at idx 0 with the new snapshot.
6. Assert sys_rst one cycle with 3 pixels in flight -> no o_valid afterwards. o_x/o_y restart at (0,0). Channels disabled, so input 16'hF800 gives o_class white or black per threshold.
